// File: rtl/instr_fetch_if.sv
// Instruction-memory read channel between the fetch stage and memory.
// Request is held by the master until the slave acknowledges it.
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, instruction register and next-PC resolution.
// One instruction in flight; each one takes at least REQ + ISSUE cycles.
module instr_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    instr_fetch_if.master     imem,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    input  logic              ex_hold,
    input  logic              branch,
    input  logic              zero,
    input  logic              bgtz,
    input  logic              gtz,
    input  logic              jump,
    input  logic              jal,
    input  logic              jsp,
    input  logic [ADDR_W-1:0] jsp_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link,
    output logic              addr_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ISSUE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              load_ir;
    logic              advance;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] next_pc;
    logic              jsp_misaligned;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = REQ;
            REQ:     if (imem.imem_ack) state_n = ISSUE;
            ISSUE:   if (!ex_hold) state_n = REQ;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        load_ir       = 1'b0;
        advance       = 1'b0;
        unique case (state)
            REQ: begin
                imem.imem_req = 1'b1;
                load_ir       = imem.imem_ack;
            end
            ISSUE: begin
                instr_valid = 1'b1;
                advance     = !ex_hold;
            end
            default: ;
        endcase
    end

    assign imem.imem_addr = pc;
    assign opcode         = instr[31:26];
    assign link           = pc4;

    assign pc4       = pc + ADDR_W'(4);
    assign br_off    = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
    assign br_target = pc4 + br_off;
    assign j_target  = {pc4[ADDR_W-1:28], instr[25:0], 2'b00};

    assign jsp_misaligned = jsp && (jsp_target[1:0] != 2'b00);

    // Stack-pointer return wins over every other redirect.
    always_comb begin
        next_pc = pc4;
        if (jsp)
            next_pc = {jsp_target[ADDR_W-1:2], 2'b00};
        else if (jump || jal)
            next_pc = j_target;
        else if ((branch && zero) || (bgtz && gtz))
            next_pc = br_target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            instr    <= '0;
            addr_err <= 1'b0;
        end else begin
            if (load_ir)
                instr <= imem.imem_rdata;
            if (advance) begin
                pc <= next_pc;
                if (jsp_misaligned)
                    addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a table of fetched instructions with
// their redirects, plus reset-abort sequences.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        ex_hold;
    logic        branch, zero, bgtz, gtz, jump, jal, jsp;
    logic [31:0] jsp_target;
    logic [31:0] pc;
    logic [31:0] link;
    logic        addr_err;

    int total = 0;
    int passed = 0;

    instr_fetch_if #(.ADDR_W(32)) bus ();

    instr_fetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem       (bus.master),
        .instr      (instr),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .ex_hold    (ex_hold),
        .branch     (branch),
        .zero       (zero),
        .bgtz       (bgtz),
        .gtz        (gtz),
        .jump       (jump),
        .jal        (jal),
        .jsp        (jsp),
        .jsp_target (jsp_target),
        .pc         (pc),
        .link       (link),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    // ctl = {branch, zero, bgtz, gtz, jump, jal, jsp}
    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [6:0]  ctl;
        logic [31:0] jt;
        int          ack_dly;
        int          hold;
        logic [31:0] link;
        logic        err;
    } vec_t;

    vec_t tv[14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic [6:0] c, input logic [31:0] t);
        {branch, zero, bgtz, gtz, jump, jal, jsp} = c;
        jsp_target = t;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (bus.imem_req !== 1'b1) begin
            total++;
            $display("FAIL req_timeout: got req=%0b expected 1", bus.imem_req);
        end
    endtask

    initial begin
        tv[0]  = '{32'h0000_0000, 32'h0000_0020, 7'b0000000, 32'h0, 0, 0, 32'h0000_0004, 1'b0};
        tv[1]  = '{32'h0000_0004, 32'h0800_0040, 7'b0000100, 32'h0, 4, 0, 32'h0000_0008, 1'b0};
        tv[2]  = '{32'h0000_0100, 32'h1000_FFFE, 7'b1100000, 32'h0, 0, 3, 32'h0000_0104, 1'b0};
        tv[3]  = '{32'h0000_00FC, 32'h0800_0040, 7'b0000100, 32'h0, 0, 0, 32'h0000_0100, 1'b0};
        tv[4]  = '{32'h0000_0100, 32'h1000_FFFE, 7'b1000000, 32'h0, 0, 0, 32'h0000_0104, 1'b0};
        tv[5]  = '{32'h0000_0104, 32'h1C00_0003, 7'b0011000, 32'h0, 0, 0, 32'h0000_0108, 1'b0};
        tv[6]  = '{32'h0000_0114, 32'h1C00_0003, 7'b0010000, 32'h0, 0, 0, 32'h0000_0118, 1'b0};
        tv[7]  = '{32'h0000_0118, 32'h0000_0000, 7'b0000001, 32'h3000_0010, 0, 0, 32'h0000_011C, 1'b0};
        tv[8]  = '{32'h3000_0010, 32'h0C00_0040, 7'b0000010, 32'h0, 0, 0, 32'h3000_0014, 1'b0};
        tv[9]  = '{32'h3000_0100, 32'h0800_0040, 7'b0000101, 32'h0000_2002, 0, 0, 32'h3000_0104, 1'b1};
        tv[10] = '{32'h0000_2000, 32'h0000_0000, 7'b0000000, 32'h0, 0, 0, 32'h0000_2004, 1'b1};
        tv[11] = '{32'h0000_2004, 32'h0000_0000, 7'b0000001, 32'hFFFF_FFFC, 0, 0, 32'h0000_2008, 1'b1};
        tv[12] = '{32'hFFFF_FFFC, 32'h0000_0000, 7'b0000000, 32'h0, 0, 0, 32'h0000_0000, 1'b1};
        tv[13] = '{32'h0000_0000, 32'h0800_0010, 7'b0000100, 32'h0, 0, 0, 32'h0000_0004, 1'b1};

        reset          = 1'b1;
        ex_hold        = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        set_ctl(7'b0, 32'h0);
        step();
        step();
        chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", instr, 32'h0);
        chk("rst_err", {31'b0, addr_err}, 32'h0);

        reset = 1'b0;
        step();

        for (int i = 0; i < 14; i++) begin
            wait_req();
            chk($sformatf("v%0d_addr", i), bus.imem_addr, tv[i].addr);
            for (int d = 0; d < tv[i].ack_dly; d++) begin
                step();
                chk($sformatf("v%0d_dly_req", i), {31'b0, bus.imem_req}, 32'h1);
                chk($sformatf("v%0d_dly_addr", i), bus.imem_addr, tv[i].addr);
            end
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = tv[i].rdata;
            ex_hold        = (tv[i].hold > 0);
            set_ctl(tv[i].ctl, tv[i].jt);
            step();
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = 32'hBAD0_BAD0;
            chk($sformatf("v%0d_valid", i), {31'b0, instr_valid}, 32'h1);
            chk($sformatf("v%0d_ir", i), instr, tv[i].rdata);
            chk($sformatf("v%0d_opc", i), {26'b0, opcode}, {26'b0, tv[i].rdata[31:26]});
            chk($sformatf("v%0d_pc", i), pc, tv[i].addr);
            chk($sformatf("v%0d_link", i), link, tv[i].link);
            chk($sformatf("v%0d_req_lo", i), {31'b0, bus.imem_req}, 32'h0);
            for (int h = 0; h < tv[i].hold; h++) begin
                step();
                chk($sformatf("v%0d_hold_valid", i), {31'b0, instr_valid}, 32'h1);
                chk($sformatf("v%0d_hold_req", i), {31'b0, bus.imem_req}, 32'h0);
                chk($sformatf("v%0d_hold_ir", i), instr, tv[i].rdata);
                chk($sformatf("v%0d_hold_pc", i), pc, tv[i].addr);
            end
            ex_hold = 1'b0;
            step();
            set_ctl(7'b0, 32'h0);
            chk($sformatf("v%0d_err", i), {31'b0, addr_err}, {31'b0, tv[i].err});
        end

        // Abort a pending fetch at 0x40; a late ack in IDLE must be dropped.
        wait_req();
        chk("abort_addr", bus.imem_addr, 32'h0000_0040);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_idle_req", {31'b0, bus.imem_req}, 32'h0);
        chk("abort_err_clr", {31'b0, addr_err}, 32'h0);
        chk("abort_pc", pc, 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        step();
        bus.imem_ack = 1'b0;
        chk("late_ack_req", {31'b0, bus.imem_req}, 32'h1);
        chk("late_ack_addr", bus.imem_addr, 32'h0);
        chk("late_ack_ir", instr, 32'h0);
        chk("late_ack_valid", {31'b0, instr_valid}, 32'h0);

        // Reset in ISSUE overrides ex_hold.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h1234_5678;
        ex_hold        = 1'b1;
        step();
        bus.imem_ack = 1'b0;
        chk("issue_valid", {31'b0, instr_valid}, 32'h1);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        ex_hold = 1'b0;
        chk("issue_rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("issue_rst_ir", instr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter: ADDR_W, 32, PC and instruction-memory address width.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: imem_req  output  1  instruction-memory read request, held until ack.
REQ-006 Port: imem_addr  output  ADDR_W  word-aligned fetch address (= pc).
REQ-007 Port: imem_ack  input  1  read data valid this cycle.
REQ-008 Port: imem_rdata  input  32  instruction word.
REQ-009 Port: instr  output  32  instruction register (IR).
REQ-010 Port: opcode  output  6  IR[31:26], drives control decoder input.
REQ-011 Port: instr_valid  output  1  IR holds an instruction being executed.
REQ-012 Port: ex_hold  input  1  downstream not done; keep current instruction.
REQ-013 Port: branch, zero, bgtz, gtz, jump, jal, jsp  input  1 each  control/datapath resolve signals, sampled only when instr_valid=1.
REQ-014 Port: jsp_target  input  ADDR_W  target for jsp (memory at stack pointer).
REQ-015 Port: pc  output  ADDR_W  address of instruction in IR.
REQ-016 Port: link  output  ADDR_W  pc+4, write-back value for jal.
REQ-017 Port: addr_err  output  1  sticky misaligned-jsp-target flag.

Function
REQ-018 FSM states: IDLE, REQ, ISSUE.
REQ-019 IDLE: imem_req=0, instr_valid=0; next state REQ unconditionally.
REQ-020 REQ: imem_req=1, imem_addr=pc; on imem_ack=1 IR<=imem_rdata, go ISSUE; else stay REQ.
REQ-021 ISSUE: instr_valid=1, imem_req=0; ex_hold=1 -> stay ISSUE, IR/pc unchanged; ex_hold=0 -> pc<=next_pc, go REQ.
REQ-022 imem_ack outside REQ is ignored.
REQ-023 Minimum instruction period 2 cycles (REQ with same-cycle ack, then ISSUE).
REQ-024 pc4 = pc+4, modulo 2^ADDR_W (0xFFFF_FFFC -> 0x0000_0000).
REQ-025 br_target = pc4 + (sign-extended IR[15:0] << 2), modulo 2^ADDR_W.
REQ-026 j_target = {pc4[31:28], IR[25:0], 2'b00}.
REQ-027 next_pc priority: jsp -> {jsp_target[31:2],2'b00}; else jump or jal -> j_target; else (branch&zero) or (bgtz&gtz) -> br_target; else pc4.
REQ-028 jsp with jsp_target[1:0]!=0 sets addr_err=1 (held until reset); fetch proceeds with aligned target.
REQ-029 link = pc4, combinational, valid while instr_valid=1.
REQ-030 opcode always equals instr[31:26].

Reset
REQ-031 reset=1 forces, next edge: state=IDLE, pc=RESET_PC, IR=0, addr_err=0; outputs imem_req=0, instr_valid=0.
REQ-032 reset overrides all inputs, including imem_ack and ex_hold, in any state.
REQ-033 Reset mid-REQ abandons the request; a late ack in IDLE is discarded; refetch starts from RESET_PC.

Verification
REQ-034 Reset release, imem_ack same-cycle, word 0x0000_0020 -> imem_addr 0x0 cycle 1, instr_valid cycle 2, opcode=0, next imem_addr 0x4.
REQ-035 pc=0x100, IR imm=0xFFFE, branch=1, zero=1 -> next imem_addr 0x0FC; same with zero=0 -> 0x104.
REQ-036 pc=0x3000_0010, IR[25:0]=0x0000040, jal=1 -> link 0x3000_0014, next imem_addr 0x3000_0100.
REQ-037 jsp=1, jump=1, jsp_target=0x0000_2002 -> next imem_addr 0x0000_2000, addr_err=1 until reset.
REQ-038 ex_hold=1 for 3 cycles in ISSUE -> instr/pc stable, imem_req=0; ack delayed 4 cycles -> imem_req held, imem_addr stable.
REQ-039 reset asserted during REQ at pc=0x40, ack arrives in IDLE -> ack ignored, next request address RESET_PC.
